// File: rtl/mem_access_ctrl_if.sv
// Request/response handshake between CPU-side logic and the memory sequencer.
// The CPU side is the master; mem_access_ctrl is the slave.
interface mem_access_ctrl_if;
  logic       req_valid;
  logic       req_ready;
  logic       req_write;
  logic [4:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       busy;

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, busy
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, busy
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Bus-master sequencer for the 32-byte main memory: single-byte reads/writes
// with registered strobes and a guaranteed idle turnaround cycle between transactions.
module mem_access_ctrl #(
  parameter int unsigned READ_WAIT = 1
) (
  input  logic                clk,
  input  logic                rst,
  mem_access_ctrl_if.slave    cpu,
  output logic                mem_read_en,
  output logic                mem_write_en,
  output logic [4:0]          mem_address,
  inout  wire  [7:0]          mem_data
);

  typedef enum logic [2:0] {
    IDLE,
    RD,
    WR_SETUP,
    WR_STROBE,
    WR_HOLD
  } state_t;

  state_t     state, state_nxt;
  logic [2:0] wait_cnt, wait_nxt;
  logic [7:0] wdata_q, wdata_nxt;
  logic [7:0] rdata_nxt;
  logic [4:0] addr_nxt;
  logic       drive_q, drive_nxt;
  logic       rd_nxt, wr_nxt, rsp_nxt, ready_nxt;
  logic       accept;

  // The bus is only driven from a registered flag, so release is glitch-free.
  assign mem_data = drive_q ? wdata_q : 'z;

  always_comb begin
    state_nxt = state;
    wait_nxt  = wait_cnt;
    wdata_nxt = wdata_q;
    rdata_nxt = cpu.rsp_rdata;
    addr_nxt  = mem_address;
    drive_nxt = drive_q;
    rd_nxt    = mem_read_en;
    wr_nxt    = 1'b0;
    rsp_nxt   = 1'b0;
    ready_nxt = cpu.req_ready;
    accept    = cpu.req_valid && cpu.req_ready;

    case (state)
      IDLE: begin
        if (accept) begin
          addr_nxt  = cpu.req_addr;
          wdata_nxt = cpu.req_wdata;
          ready_nxt = 1'b0;
          if (cpu.req_write) begin
            state_nxt = WR_SETUP;
            drive_nxt = 1'b1;
          end else begin
            state_nxt = RD;
            rd_nxt    = 1'b1;
            wait_nxt  = 3'(READ_WAIT);
          end
        end
      end
      RD: begin
        if (wait_cnt == 3'd1) begin
          rdata_nxt = mem_data;
          rsp_nxt   = 1'b1;
          rd_nxt    = 1'b0;
          ready_nxt = 1'b1;
          state_nxt = IDLE;
        end else begin
          wait_nxt = wait_cnt - 3'd1;
        end
      end
      WR_SETUP: begin
        wr_nxt    = 1'b1;
        state_nxt = WR_STROBE;
      end
      WR_STROBE: begin
        state_nxt = WR_HOLD;
      end
      WR_HOLD: begin
        drive_nxt = 1'b0;
        rsp_nxt   = 1'b1;
        ready_nxt = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        drive_nxt = 1'b0;
        rd_nxt    = 1'b0;
        ready_nxt = 1'b1;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      wait_cnt      <= '0;
      wdata_q       <= '0;
      drive_q       <= 1'b0;
      mem_read_en   <= 1'b0;
      mem_write_en  <= 1'b0;
      mem_address   <= '0;
      cpu.req_ready <= 1'b1;
      cpu.busy      <= 1'b0;
      cpu.rsp_valid <= 1'b0;
      cpu.rsp_rdata <= '0;
    end else begin
      state         <= state_nxt;
      wait_cnt      <= wait_nxt;
      wdata_q       <= wdata_nxt;
      drive_q       <= drive_nxt;
      mem_read_en   <= rd_nxt;
      mem_write_en  <= wr_nxt;
      mem_address   <= addr_nxt;
      cpu.req_ready <= ready_nxt;
      cpu.busy      <= ~ready_nxt;
      cpu.rsp_valid <= rsp_nxt;
      cpu.rsp_rdata <= rdata_nxt;
    end
  end

endmodule
